// File: rtl/dir_input_conditioner.sv
// Button front end for the adventure-game FSM: sync, debounce and one-hot move pulses.
// Define DIR_AUTOREPEAT_EN to re-emit a held direction every REPEAT_CYCLES cycles.
module dir_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    input  logic btn_s,
    input  logic btn_e,
    input  logic btn_w,
    input  logic hold,
    output logic n,
    output logic s,
    output logic e,
    output logic w
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_badParam
            $error("dir_input_conditioner: DEBOUNCE_CYCLES must be >= 1 and REPEAT_CYCLES >= 2");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } state_t;

    // Bit order everywhere: [0]=N, [1]=S, [2]=E, [3]=W.
    logic [3:0]       w_raw;
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_stable;
    logic [CNT_W-1:0] r_cnt [4];

    state_t     r_state;
    state_t     w_nextState;
    logic [3:0] r_out;
    logic [3:0] w_nextOut;
    logic [3:0] w_pick;

    assign w_raw = {btn_w, btn_e, btn_s, btn_n};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // A level is accepted only after it has differed from the accepted level
    // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_pick = '0;
        if (r_stable[0]) begin
            w_pick = 4'b0001;
        end else if (r_stable[1]) begin
            w_pick = 4'b0010;
        end else if (r_stable[2]) begin
            w_pick = 4'b0100;
        end else if (r_stable[3]) begin
            w_pick = 4'b1000;
        end
    end

`ifdef DIR_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);

    logic [3:0]       r_dir;
    logic [3:0]       w_nextDir;
    logic [RPT_W-1:0] r_rptCnt;
    logic [RPT_W-1:0] w_nextRpt;

    // r_dir holds the direction eligible for repeat; zero means repeat is off
    // until the next fresh press from IDLE.
    always_comb begin
        w_nextState = r_state;
        w_nextOut   = '0;
        w_nextDir   = r_dir;
        w_nextRpt   = '0;
        if (hold) begin
            w_nextState = ST_LOCK;
            w_nextDir   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|r_stable) begin
                        w_nextOut   = w_pick;
                        w_nextDir   = w_pick;
                        w_nextState = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (r_stable == 4'b0000) begin
                        w_nextState = ST_IDLE;
                        w_nextDir   = '0;
                    end else if (r_dir != 4'b0000 && r_stable == r_dir) begin
                        if (r_rptCnt == RPT_MAX) begin
                            w_nextOut = r_dir;
                        end else begin
                            w_nextRpt = r_rptCnt + RPT_W'(1);
                        end
                    end else begin
                        w_nextDir = '0;
                    end
                end
                default: begin
                    w_nextState = ST_IDLE;
                    w_nextDir   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dir    <= '0;
            r_rptCnt <= '0;
        end else begin
            r_dir    <= w_nextDir;
            r_rptCnt <= w_nextRpt;
        end
    end
`else
    // Lower-priority simultaneous presses are dropped; LOCK waits for all-released.
    always_comb begin
        w_nextState = r_state;
        w_nextOut   = '0;
        if (hold) begin
            w_nextState = ST_LOCK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|r_stable) begin
                        w_nextOut   = w_pick;
                        w_nextState = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (r_stable == 4'b0000) begin
                        w_nextState = ST_IDLE;
                    end
                end
                default: begin
                    w_nextState = ST_IDLE;
                end
            endcase
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
        end else begin
            r_state <= w_nextState;
            r_out   <= w_nextOut;
        end
    end

    assign n = r_out[0];
    assign s = r_out[1];
    assign e = r_out[2];
    assign w = r_out[3];

endmodule

// File: doc/dir_input_conditioner.md
Name: dir_input_conditioner

Overview:
- Upstream front end for the adventure-game FSM. Converts four raw, asynchronous, bouncing push-button lines into clean single-cycle one-hot n/s/e/w move pulses, one pulse per press.
- Takes a hold input, driven by the game's d | win, which freezes move generation once the game is over.
- Sits between board buttons and the game FSM's n/s/e/w inputs.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized level must differ from the accepted level before it is accepted (min 1).
- REPEAT_CYCLES, 16: auto-repeat interval in cycles. Used only when DIR_AUTOREPEAT_EN is defined (min 2).

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- btn_n, btn_s, btn_e, btn_w  in  1 each  raw button levels, asynchronous, active-high, may bounce.
- hold  in  1  synchronous; 1 = suppress all moves (game over).
- n, s, e, w  out  1 each  registered move pulses, at most one high in any cycle.

Behaviour:
- Reset (reset_n=0, async): n=s=e=w=0, sync flops=0, stable levels=0, debounce counters=0, FSM=IDLE. Release is synchronous to clk by the system.
- Sync: each btn_* passes through a 2-flop synchronizer (sync1 -> sync2).
- Debounce, per button:
  - if sync2 == stable: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0.
  - else: cnt <= cnt+1.
  - cnt width = $clog2(DEBOUNCE_CYCLES)+1.
  - Debouncers run continuously, including while hold=1.
- FSM, 2 states, outputs registered:
  - IDLE: if hold=0 and any stable=1, assert exactly one output next cycle by priority N > S > E > W, then go to LOCK. Lower-priority simultaneous presses are dropped, not queued.
  - LOCK: outputs 0. Go to IDLE when all four stable levels = 0.
  - hold=1 in any state: outputs forced 0 next edge, FSM <= LOCK. A button held across hold deassertion therefore never fires; it must be released first.
- Pulse width: exactly 1 cycle per press (non-repeat build).
- Latency: btn rises and is first sampled at edge 0. sync2=1 after edge 1. stable=1 after edge DEBOUNCE_CYCLES+1. Output high during the cycle after edge DEBOUNCE_CYCLES+2, low after edge DEBOUNCE_CYCLES+3. With the default of 4: high after edge 6, low after edge 7.
- Release: the stable level falls DEBOUNCE_CYCLES+1 edges after the raw fall is sampled. The FSM returns to IDLE one edge later.
- Glitch rejection: a raw pulse or bounce shorter than DEBOUNCE_CYCLES consecutive synchronized cycles produces no output. Any return to the stable value clears cnt.
- Simultaneous events:
  - Two buttons reaching stable=1 on the same edge: the higher priority fires. LOCK is then held until both are released.
  - A new press while in LOCK is ignored.
- Reset mid-operation: an in-flight pulse is cleared immediately. A button still held after reset release is re-debounced and fires once, with full latency.

Optional Feature:
- Macro: DIR_AUTOREPEAT_EN.
- Defined:
  - LOCK keeps rpt_cnt (width $clog2(REPEAT_CYCLES)+1), cleared on entering LOCK.
  - While the fired direction's stable level stays 1, hold=0, and all other stable levels are 0, rpt_cnt increments.
  - On reaching REPEAT_CYCLES-1, re-emit the same direction for 1 cycle and clear rpt_cnt. Pulses are therefore spaced REPEAT_CYCLES cycles apart.
  - Any other button stable=1 or hold=1 clears rpt_cnt and stops repeat.
- Undefined: no rpt_cnt logic. Exactly one pulse per press regardless of hold time.

Test Plan:
- Reset, then btn_e=1 from edge 0, held 20 cycles -> e=1 only during the cycle after edge 6, n=s=w=0 throughout, exactly one pulse (macro undefined).
- btn_n toggled 1,0,1,0,1 one cycle each, then 0 -> no output ever. Then a clean 10-cycle press -> one n pulse.
- btn_s and btn_w rise on the same edge, held 10 cycles -> single s pulse, w never asserted. Release both, re-press w -> single w pulse.
- hold=1 while btn_n is pressed; btn_n kept high, hold dropped after 15 cycles -> no n pulse until btn_n is released and pressed again.
- reset_n pulsed low the cycle after an e pulse is asserted -> e falls asynchronously. btn_e still held -> one e pulse 7 edges after reset release.
- DIR_AUTOREPEAT_EN defined, REPEAT_CYCLES=16, btn_w held 60 cycles -> w pulses at the cycles after edges 6, 22, 38, 54, and no others.
